// File: rtl/cpu_pkg.sv
// cpu_pkg: state encoding, opcode constants, opcode classes and pc_src/wb_sel encodings
package cpu_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;
  typedef enum logic [2:0] {C_NONE, C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP} cls_t;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic PC_PLUS4  = 1'b0;
  localparam logic PC_TARGET = 1'b1;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: maps opcode[6:0] to an instruction class (cls) and a legal flag
module opcode_classifier
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       legal,
  output cls_t       cls
);
  always_comb begin
    case (opcode)
      OPC_LOAD:                              cls = C_LOAD;
      OPC_STORE:                             cls = C_STORE;
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: cls = C_ALU;
      OPC_BRANCH:                            cls = C_BRANCH;
      OPC_JAL, OPC_JALR:                     cls = C_JUMP;
      default:                               cls = C_NONE;
    endcase
  end
  assign legal = cls != C_NONE;
endmodule

// File: rtl/cpu_cycle_sequencer.sv
// cpu_cycle_sequencer: multi-cycle control FSM; run/opcode/br_taken/mem_ack in, datapath enables, memory controls, state/busy/trap out
module cpu_cycle_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_ack,
  output logic       pc_en,
  output logic       ir_en,
  output logic       opnd_en,
  output logic       alu_en,
  output logic       mdr_en,
  output logic       rf_we,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       pc_src,
  output logic [1:0] wb_sel,
  output logic [2:0] state,
  output logic       busy,
  output logic       trap
);
  localparam logic [7:0] LIM = 8'(MEM_TIMEOUT - 1);
  state_t     state_q, state_n, fin;
  cls_t       cls_q, cls_d;
  logic       legal, timeout, waiting;
  logic [7:0] cnt;
  opcode_classifier u_cls (
    .opcode(opcode),
    .legal (legal),
    .cls   (cls_d)
  );
  assign waiting = state_q == S_FETCH || state_q == S_MEM;
  assign timeout = !mem_ack && cnt == LIM;
  assign fin     = run ? S_FETCH : S_IDLE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cls_q   <= C_NONE;
      cnt     <= '0;
    end else begin
      state_q <= state_n;
      if (state_q == S_DECODE) cls_q <= cls_d;
      cnt <= (waiting && state_n == state_q) ? cnt + 8'd1 : '0;
    end
  end
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:   state_n = run ? S_FETCH : S_IDLE;
      S_FETCH:  state_n = mem_ack ? S_DECODE : timeout ? S_TRAP : S_FETCH;
      S_DECODE: state_n = legal ? S_EXEC : S_TRAP;
      S_EXEC:   state_n = cls_q == C_BRANCH ? fin : (cls_q == C_LOAD || cls_q == C_STORE) ? S_MEM : S_WB;
      S_MEM:    state_n = mem_ack ? (cls_q == C_LOAD ? S_WB : fin) : timeout ? S_TRAP : S_MEM;
      S_WB:     state_n = fin;
      default:  state_n = S_TRAP;
    endcase
  end
  always_comb begin
    pc_en    = 1'b0;
    ir_en    = 1'b0;
    opnd_en  = 1'b0;
    alu_en   = 1'b0;
    mdr_en   = 1'b0;
    rf_we    = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    pc_src   = PC_PLUS4;
    wb_sel   = WB_ALU;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_en   = mem_ack;
      end
      S_DECODE: opnd_en = 1'b1;
      S_EXEC: begin
        alu_en = 1'b1;
        pc_en  = cls_q == C_BRANCH;
        pc_src = cls_q == C_BRANCH ? br_taken : PC_PLUS4;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = cls_q == C_STORE;
        mdr_en   = cls_q == C_LOAD && mem_ack;
        pc_en    = cls_q == C_STORE && mem_ack;
      end
      S_WB: begin
        rf_we  = 1'b1;
        pc_en  = 1'b1;
        pc_src = cls_q == C_JUMP ? PC_TARGET : PC_PLUS4;
        wb_sel = cls_q == C_LOAD ? WB_MDR : cls_q == C_JUMP ? WB_PC4 : WB_ALU;
      end
      default: ;
    endcase
  end
  assign state = state_q;
  assign busy  = state_q != S_IDLE && state_q != S_TRAP;
  assign trap  = state_q == S_TRAP;
endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// tb_cpu_cycle_sequencer: directed instruction scripts expanded into expected per-cycle traces, checked every cycle
module tb_cpu_cycle_sequencer;
  import cpu_pkg::*;
  typedef struct packed {
    logic [2:0] st;
    logic busy, trap, pc_en, ir_en, opnd_en, alu_en, mdr_en, rf_we, mem_req, mem_we, addr_sel, pc_src;
    logic [1:0] wb_sel;
  } obs_t;
  typedef enum {K_ALU, K_LOAD, K_STORE, K_BR, K_JMP, K_BAD} kind_t;
  logic clk = 0, rst = 0, run = 0, br_taken = 0, mem_ack = 0;
  logic [6:0] opcode = 7'd0;
  logic pc_en, ir_en, opnd_en, alu_en, mdr_en, rf_we, mem_req, mem_we, addr_sel, pc_src, busy, trap;
  logic [1:0] wb_sel;
  logic [2:0] state;
  obs_t act;
  obs_t exp_q[$];
  string tag_q[$];
  int compared = 0, mismatched = 0, busy_cnt = 0;
  always #5 clk = ~clk;
  cpu_cycle_sequencer #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .br_taken(br_taken), .mem_ack(mem_ack),
    .pc_en(pc_en), .ir_en(ir_en), .opnd_en(opnd_en), .alu_en(alu_en), .mdr_en(mdr_en), .rf_we(rf_we),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .pc_src(pc_src), .wb_sel(wb_sel),
    .state(state), .busy(busy), .trap(trap)
  );
  assign act = {state, busy, trap, pc_en, ir_en, opnd_en, alu_en, mdr_en, rf_we, mem_req, mem_we, addr_sel, pc_src, wb_sel};
  always @(negedge clk) begin
    obs_t e;
    string t;
    if (busy) busy_cnt++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      compared++;
      if (act !== e) begin
        mismatched++;
        $display("FAIL %s: got %h want %h", t, act, e);
      end
    end
  end
  function automatic kind_t kind_of(input logic [6:0] op);
    case (op)
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111: return K_ALU;
      7'b1100011: return K_BR;
      7'b1101111, 7'b1100111: return K_JMP;
      default: return K_BAD;
    endcase
  endfunction
  function automatic obs_t base(input state_t s);
    obs_t r = '0;
    r.st = s;
    r.busy = s != S_IDLE && s != S_TRAP;
    r.trap = s == S_TRAP;
    return r;
  endfunction
  function automatic obs_t f_fetch(input logic ack);
    obs_t r = base(S_FETCH);
    r.mem_req = 1'b1;
    r.ir_en = ack;
    return r;
  endfunction
  function automatic obs_t f_dec();
    obs_t r = base(S_DECODE);
    r.opnd_en = 1'b1;
    return r;
  endfunction
  function automatic obs_t f_exec(input kind_t k, input logic br);
    obs_t r = base(S_EXEC);
    r.alu_en = 1'b1;
    if (k == K_BR) begin
      r.pc_en = 1'b1;
      r.pc_src = br;
    end
    return r;
  endfunction
  function automatic obs_t f_mem(input kind_t k, input logic ack);
    obs_t r = base(S_MEM);
    r.mem_req = 1'b1;
    r.addr_sel = 1'b1;
    r.mem_we = k == K_STORE;
    r.mdr_en = k == K_LOAD && ack;
    r.pc_en = k == K_STORE && ack;
    return r;
  endfunction
  function automatic obs_t f_wb(input kind_t k);
    obs_t r = base(S_WB);
    r.rf_we = 1'b1;
    r.pc_en = 1'b1;
    r.wb_sel = k == K_LOAD ? 2'd1 : k == K_JMP ? 2'd2 : 2'd0;
    r.pc_src = k == K_JMP;
    return r;
  endfunction
  task automatic cyc(input logic rs, input logic r, input logic [6:0] op, input logic br, input logic ack, input obs_t e, input string t);
    @(posedge clk);
    #1;
    rst = rs;
    run = r;
    opcode = op;
    br_taken = br;
    mem_ack = ack;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask
  task automatic lit(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask
  task automatic idle(input logic r);
    cyc(1, r, 7'd0, 0, 1, base(S_IDLE), "idle");
  endtask
  // opcode is only valid in DECODE; elsewhere 0 is driven so the latched class is exercised
  task automatic instr(input logic [6:0] op, input int fw, input int mw, input logic br, input logic rn);
    kind_t k = kind_of(op);
    for (int i = 0; i < fw; i++) cyc(1, 1, 7'd0, 0, 0, f_fetch(0), "fetch_wait");
    cyc(1, 1, 7'd0, 0, 1, f_fetch(1), "fetch_ack");
    cyc(1, 1, op, 0, 1, f_dec(), "decode");
    if (k == K_BAD) return;
    cyc(1, rn, 7'd0, br, 1, f_exec(k, br), "exec");
    if (k == K_LOAD || k == K_STORE) begin
      for (int i = 0; i < mw; i++) cyc(1, rn, 7'd0, br, 0, f_mem(k, 0), "mem_wait");
      cyc(1, rn, 7'd0, br, 1, f_mem(k, 1), "mem_ack");
    end
    if (k != K_STORE && k != K_BR) cyc(1, rn, 7'd0, br, 1, f_wb(k), "wb");
  endtask
  task automatic trap_then_reset(input int n);
    cyc(1, 1, 7'd0, 1, 1, base(S_TRAP), "trap");
    lit("trap_flags", int'({trap, busy}), 2);
    for (int i = 1; i < n; i++) cyc(1, 1, 7'd0, 1, 1, base(S_TRAP), "trap_hold");
    cyc(0, 1, 7'd0, 0, 1, base(S_TRAP), "trap_rst");
    cyc(1, 0, 7'd0, 0, 0, base(S_IDLE), "post_rst");
  endtask
  task automatic lat(input logic [6:0] op, input int mw, input int want, input string name);
    busy_cnt = 0;
    idle(1);
    instr(op, 0, mw, 0, 0);
    idle(0);
    lit(name, busy_cnt, want);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    cyc(1, 0, 7'd0, 0, 0, base(S_IDLE), "reset_idle");
    lit("reset_state", int'({state, busy, trap, pc_src, wb_sel, mem_req}), 0);
    idle(0);
    lat(7'b0110011, 0, 4, "lat_op");
    lat(7'b0000011, 0, 5, "lat_load");
    lat(7'b0100011, 0, 4, "lat_store");
    lat(7'b1100011, 0, 3, "lat_branch");
    lat(7'b1101111, 0, 4, "lat_jal");
    lat(7'b0000011, 3, 8, "lat_load_3wait");
    idle(1);
    instr(7'b0010011, 0, 0, 0, 1);
    instr(7'b0110111, 2, 0, 0, 1);
    instr(7'b1100011, 0, 0, 1, 1);
    instr(7'b1100011, 1, 0, 0, 1);
    instr(7'b0010111, 0, 0, 1, 1);
    instr(7'b1100111, 1, 0, 1, 1);
    instr(7'b0100011, 0, 2, 0, 1);
    instr(7'b0000011, 1, 1, 0, 1);
    instr(7'b0110011, 0, 0, 0, 0);
    idle(0);
    idle(1);
    cyc(1, 1, 7'd0, 0, 1, f_fetch(1), "st_fetch");
    cyc(1, 1, 7'b0100011, 0, 0, f_dec(), "st_decode");
    cyc(1, 1, 7'd0, 0, 0, f_exec(K_STORE, 0), "st_exec");
    cyc(1, 1, 7'd0, 0, 0, f_mem(K_STORE, 0), "st_mem");
    cyc(0, 1, 7'd0, 0, 0, f_mem(K_STORE, 0), "st_mem_rst");
    cyc(1, 0, 7'd0, 0, 0, base(S_IDLE), "st_after_rst");
    idle(1);
    instr(7'b0000000, 0, 0, 0, 1);
    trap_then_reset(3);
    idle(1);
    for (int i = 0; i < 16; i++) cyc(1, 1, 7'd0, 0, 0, f_fetch(0), "fetch_timeout");
    trap_then_reset(4);
    idle(1);
    instr(7'b0010011, 15, 0, 0, 0);
    idle(0);
    idle(1);
    cyc(1, 1, 7'd0, 0, 1, f_fetch(1), "ld_fetch");
    cyc(1, 1, 7'b0000011, 0, 1, f_dec(), "ld_decode");
    cyc(1, 1, 7'd0, 0, 1, f_exec(K_LOAD, 0), "ld_exec");
    for (int i = 0; i < 16; i++) cyc(1, 1, 7'd0, 0, 0, f_mem(K_LOAD, 0), "mem_timeout");
    trap_then_reset(2);
    idle(0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/cpu_cycle_sequencer.md
CPU_CYCLE_SEQUENCER -- requirements
Module: cpu_cycle_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum number of cycles to wait for mem_ack before trapping (range 2..255).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port run  input  1  start and continue instruction execution.
REQ-005 SHALL have port opcode  input  7  instruction-register bits [6:0].
REQ-006 SHALL have port br_taken  input  1  branch condition from the ALU compare.
REQ-007 SHALL have port mem_ack  input  1  memory transfer complete this cycle.
REQ-008 SHALL have ports pc_en, ir_en, opnd_en, alu_en, mdr_en, rf_we  output  1 each  load enables for the datapath 32-bit registers.
REQ-009 SHALL have ports mem_req, mem_we, addr_sel  output  1 each  memory request, write strobe, and address source (0=PC, 1=ALU out).
REQ-010 SHALL have ports pc_src  output  1 (0=PC+4, 1=ALU target) and wb_sel  output  2 (0=ALU, 1=MDR, 2=PC+4).
REQ-011 SHALL have ports state  output  3  current state code, busy  output  1, and trap  output  1.

Function
REQ-012 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-013 IDLE: all enables 0 and busy=0; run=1 -> FETCH.
REQ-014 FETCH: mem_req=1, addr_sel=0; ir_en=mem_ack (same cycle); on mem_ack -> DECODE.
REQ-015 DECODE: opnd_en=1; legal opcode -> EXEC; any other opcode -> TRAP.
REQ-016 Legal opcodes: LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-017 EXEC: alu_en=1; LOAD/STORE -> MEM; JAL/JALR/OP/OP-IMM/LUI/AUIPC -> WB.
REQ-018 EXEC with BRANCH: pc_en=1, pc_src=br_taken; the instruction is complete.
REQ-019 MEM: mem_req=1, addr_sel=1, mem_we=1 only for STORE; LOAD on ack: mdr_en=1 -> WB; STORE on ack: pc_en=1, pc_src=0; the instruction is complete.
REQ-020 WB: rf_we=1, pc_en=1; wb_sel=1 for LOAD, 2 for JAL/JALR, else 0; pc_src=1 for JAL/JALR, else 0; the instruction is complete.
REQ-021 On instruction completion: next state is FETCH if run=1, else IDLE; deassertion of run mid-instruction SHALL NOT abort that instruction.
REQ-022 Wait counter: cleared on entry to FETCH or MEM and incremented each cycle without mem_ack; reaching MEM_TIMEOUT without ack -> TRAP.
REQ-023 mem_ack in the same cycle the counter reaches its limit SHALL be treated as success.
REQ-024 mem_ack outside FETCH/MEM SHALL be ignored.
REQ-025 TRAP: trap=1, all enables 0, mem_req=0; state held until reset.
REQ-026 Outputs SHALL be combinational decodes of state, latched opcode class, and inputs; enables SHALL be asserted for exactly one cycle per occurrence.
REQ-027 Zero-wait latency: OP = 4 cycles, LOAD = 5, STORE = 4, BRANCH = 3, JAL = 4.
REQ-028 The opcode class SHALL be captured in DECODE and held through completion.
REQ-029 busy SHALL be 1 in all states except IDLE and TRAP.

Reset
REQ-030 rst=0 at a clock edge SHALL force IDLE, clear the wait counter and opcode class, and deassert all enables and mem_req the following cycle, including mid-transfer.
REQ-031 Reset values: state=IDLE, busy=0, trap=0, all enables, mem_req and mem_we 0, pc_src=0, wb_sel=0, addr_sel=0.

Structure
REQ-032 Shared package cpu_pkg SHALL hold the state encoding, opcode constants, and pc_src/wb_sel encodings.
REQ-033 Opcode legality and class decoding SHALL be a sub-module opcode_classifier.

Verification
REQ-034 ADDI 0010011, zero-wait ack, run=1: states FETCH,DECODE,EXEC,WB; rf_we and pc_en high in cycle 4; next state FETCH.
REQ-035 LOAD with ack after 3 wait cycles in MEM: mdr_en is a single pulse in the ack cycle, wb_sel=1 in WB, 8 cycles total.
REQ-036 BRANCH with br_taken=1: pc_en=1 and pc_src=1 in EXEC, rf_we never asserted.
REQ-037 FETCH with no ack for MEM_TIMEOUT=16 cycles: trap=1 and busy=0, stuck until rst; ack on the 16th cycle instead -> DECODE.
REQ-038 Opcode 0000000: TRAP after DECODE.
REQ-039 rst=0 mid-MEM of a STORE: mem_req=0 the next cycle and state=IDLE. Separately, run dropped during EXEC: the instruction completes, then state=IDLE.
